// File: rtl/updown_ctrl_pkg.sv
// rtl/updown_ctrl_pkg.sv - shared types and constants for the up/down move controller
//
// Purpose: state encoding, direction constants and default counter width
// used by updown_move_ctrl and its testbench.
package updown_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int COUNT_W_DEFAULT = 3;

endpackage

// File: rtl/dwell_timer.sv
// rtl/dwell_timer.sv - loadable down-counter timing the hold at target
//
// Purpose: counts the dwell period; last flags the final dwell cycle.
// Ports:
//   clock, reset_n  clock and asynchronous active-low reset
//   load, load_val  load the counter with load_val (wins over dec)
//   dec             decrement by one, saturating at zero
//   last            counter value equals 1
module dwell_timer #(
  parameter int DWELL_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               last
);

  logic [DWELL_W-1:0] value_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_val;
    end else if (dec && (value_q != '0)) begin
      value_q <= value_q - 1'b1;
    end
  end

  assign last = (value_q == DWELL_W'(1));

endmodule

// File: rtl/updown_move_ctrl.sv
// rtl/updown_move_ctrl.sv - steers an external up/down counter to a commanded target
//
// Purpose: accepts a (target, dwell) command, drives the counter along the
// shortest path around the ring, holds for the dwell time, then pulses done.
// Ports:
//   clock, reset_n           clock and asynchronous active-low reset
//   cmd_valid/cmd_ready      command handshake; cmd_target/cmd_dwell sampled on accept
//   abort                    terminate the active command
//   cnt_count                current counter value
//   cnt_enable/cnt_direction counter step enable and direction (1 = up)
//   busy, done, done_aborted status and one-cycle completion pulse
module updown_move_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT,
  parameter int DWELL_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COUNT_W-1:0] cmd_target,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               abort,
  input  logic [COUNT_W-1:0] cnt_count,
  output logic               cnt_enable,
  output logic               cnt_direction,
  output logic               busy,
  output logic               done,
  output logic               done_aborted
);

  // Half the ring: a distance of exactly this much goes up.
  localparam logic [COUNT_W-1:0] HALF = COUNT_W'(1 << (COUNT_W - 1));

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] target_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               dir_q;
  logic               aborted_q;

  logic [COUNT_W-1:0] dist_up;
  logic               accept;
  logic               at_target;
  logic               timer_load;
  logic               timer_dec;
  logic               timer_last;
  logic               finish_aborted;

  assign dist_up   = cmd_target - cnt_count;
  assign accept    = cmd_valid && (state_q == IDLE);
  assign at_target = (cnt_count == target_q);

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (dwell_q),
    .dec      (timer_dec),
    .last     (timer_last)
  );

  always_comb begin
    state_d        = state_q;
    cnt_enable     = 1'b0;
    timer_load     = 1'b0;
    timer_dec      = 1'b0;
    finish_aborted = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = MOVE;
      end
      MOVE: begin
        if (abort) begin
          state_d        = DONE;
          finish_aborted = 1'b1;
        end else if (at_target) begin
          if (dwell_q != '0) begin
            state_d    = DWELL;
            timer_load = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_enable = 1'b1;
        end
      end
      DWELL: begin
        timer_dec = 1'b1;
        if (abort) begin
          state_d        = DONE;
          finish_aborted = 1'b1;
        end else if (timer_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      target_q  <= '0;
      dwell_q   <= '0;
      dir_q     <= DIR_UP;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Only the cycle entering DONE matters; DONE reads it one cycle later.
      aborted_q <= finish_aborted;
      if (accept) begin
        target_q <= cmd_target;
        dwell_q  <= cmd_dwell;
        dir_q    <= (dist_up <= HALF) ? DIR_UP : DIR_DOWN;
      end
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign done_aborted  = (state_q == DONE) && aborted_q;
  assign cnt_direction = dir_q;

endmodule

// File: tb/tb_updown_move_ctrl.sv
// tb/tb_updown_move_ctrl.sv - directed self-checking bench for updown_move_ctrl
module tb_updown_move_ctrl;
  import updown_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_target;
  logic [3:0] cmd_dwell;
  logic       abort;
  logic [2:0] cnt_count = 3'd0;
  logic       cnt_enable;
  logic       cnt_direction;
  logic       busy;
  logic       done;
  logic       done_aborted;

  logic       preset_en  = 1'b0;
  logic [2:0] preset_val = 3'd0;

  int checks = 0;
  int errors = 0;

  updown_move_ctrl #(.COUNT_W(3), .DWELL_W(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_target    (cmd_target),
    .cmd_dwell     (cmd_dwell),
    .abort         (abort),
    .cnt_count     (cnt_count),
    .cnt_enable    (cnt_enable),
    .cnt_direction (cnt_direction),
    .busy          (busy),
    .done          (done),
    .done_aborted  (done_aborted)
  );

  always #5 clock = ~clock;

  // External 3-bit up/down counter driven by the controller.
  always @(posedge clock) begin
    if (preset_en) cnt_count <= preset_val;
    else if (cnt_enable) cnt_count <= cnt_direction ? cnt_count + 3'd1 : cnt_count - 3'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic preset(input logic [2:0] v);
    preset_en  = 1'b1;
    preset_val = v;
    step();
    preset_en  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".ready"}, 32'(cmd_ready), 32'd1);
    check({tag, ".en"},    32'(cnt_enable), 32'd0);
    check({tag, ".dir"},   32'(cnt_direction), 32'd1);
    check({tag, ".busy"},  32'(busy), 32'd0);
    check({tag, ".done"},  32'(done), 32'd0);
    check({tag, ".abt"},   32'(done_aborted), 32'd0);
  endtask

  // Issue one command and check every cycle until ready returns.
  task automatic run_cmd(input string tag, input logic [2:0] tgt, input logic [3:0] dw,
                         input logic abort_at_accept, input logic exp_dir,
                         input int d, input int n);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_dwell  = dw;
    abort      = abort_at_accept;
    #1;
    check({tag, ".ready0"}, 32'(cmd_ready), 32'd1);
    for (int k = 1; k <= d + 3 + n; k++) begin
      step();
      if (k == 1) begin
        cmd_valid = 1'b0;
        abort     = 1'b0;
      end
      #1;
      check($sformatf("%s.en[%0d]", tag, k),    32'(cnt_enable), 32'(k <= d));
      if (k <= d) check($sformatf("%s.dir[%0d]", tag, k), 32'(cnt_direction), 32'(exp_dir));
      check($sformatf("%s.busy[%0d]", tag, k),  32'(busy), 32'(k < d + 3 + n));
      check($sformatf("%s.done[%0d]", tag, k),  32'(done), 32'(k == d + 2 + n));
      check($sformatf("%s.abt[%0d]", tag, k),   32'(done_aborted), 32'd0);
      check($sformatf("%s.ready[%0d]", tag, k), 32'(cmd_ready), 32'(k == d + 3 + n));
    end
    check({tag, ".final_cnt"}, 32'(cnt_count), 32'(tgt));
  endtask

  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = 3'd0;
    cmd_dwell  = 4'd0;
    abort      = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();
    check_reset_outputs("post_reset");

    // 1 -> 6: dist_up 5, down through the wrap, 3 steps
    preset(3'd1);
    run_cmd("down_wrap", 3'd6, 4'd0, 1'b0, DIR_DOWN, 3, 0);

    // 2 -> 6: tie goes up, 4 steps, 3 dwell cycles
    preset(3'd2);
    run_cmd("tie_dwell", 3'd6, 4'd3, 1'b0, DIR_UP, 4, 3);

    // already at target; abort during accept has no effect
    preset(3'd5);
    run_cmd("at_target", 3'd5, 4'd0, 1'b1, DIR_UP, 0, 0);

    // 5 -> 7 with dwell 5, abort in the 2nd dwell cycle
    preset(3'd5);
    cmd_valid = 1'b1; cmd_target = 3'd7; cmd_dwell = 4'd5;
    step(); cmd_valid = 1'b0; #1;
    check("abd.en1", 32'(cnt_enable), 32'd1);
    step(); #1;
    check("abd.en2", 32'(cnt_enable), 32'd1);
    step(); #1;
    check("abd.en3", 32'(cnt_enable), 32'd0);
    step(); #1;
    check("abd.dwell1_busy", 32'(busy), 32'd1);
    check("abd.dwell1_done", 32'(done), 32'd0);
    step(); abort = 1'b1; #1;
    check("abd.dwell2_en", 32'(cnt_enable), 32'd0);
    step(); abort = 1'b0; #1;
    check("abd.done",  32'(done), 32'd1);
    check("abd.abt",   32'(done_aborted), 32'd1);
    check("abd.en_d",  32'(cnt_enable), 32'd0);
    step(); #1;
    check("abd.ready", 32'(cmd_ready), 32'd1);
    check("abd.done0", 32'(done), 32'd0);
    check("abd.cnt",   32'(cnt_count), 32'd7);

    // 7 -> 2 up through the wrap, abort in the 2nd MOVE cycle
    cmd_valid = 1'b1; cmd_target = 3'd2; cmd_dwell = 4'd0;
    step(); cmd_valid = 1'b0; #1;
    check("abm.en1",  32'(cnt_enable), 32'd1);
    check("abm.dir1", 32'(cnt_direction), 32'd1);
    step(); abort = 1'b1; #1;
    check("abm.en_forced0", 32'(cnt_enable), 32'd0);
    step(); abort = 1'b0; #1;
    check("abm.done", 32'(done), 32'd1);
    check("abm.abt",  32'(done_aborted), 32'd1);
    step(); #1;
    check("abm.ready", 32'(cmd_ready), 32'd1);
    check("abm.cnt",   32'(cnt_count), 32'd0);

    // cmd_valid held: 0 -> 1 then 1 -> 3
    cmd_valid = 1'b1; cmd_target = 3'd1; cmd_dwell = 4'd0;
    step(); cmd_target = 3'd3; #1;
    check("b2b.ready1", 32'(cmd_ready), 32'd0);
    check("b2b.en1",    32'(cnt_enable), 32'd1);
    step(); #1;
    check("b2b.ready2", 32'(cmd_ready), 32'd0);
    step(); #1;
    check("b2b.done3",  32'(done), 32'd1);
    check("b2b.ready3", 32'(cmd_ready), 32'd0);
    step(); #1;
    check("b2b.ready4", 32'(cmd_ready), 32'd1);
    check("b2b.cnt4",   32'(cnt_count), 32'd1);
    step(); cmd_valid = 1'b0; #1;
    check("b2b.busy5",  32'(busy), 32'd1);
    check("b2b.en5",    32'(cnt_enable), 32'd1);
    check("b2b.dir5",   32'(cnt_direction), 32'd1);
    step(); #1;
    check("b2b.en6",    32'(cnt_enable), 32'd1);
    step(); #1;
    check("b2b.en7",    32'(cnt_enable), 32'd0);
    check("b2b.done7",  32'(done), 32'd0);
    step(); #1;
    check("b2b.done8",  32'(done), 32'd1);
    check("b2b.cnt8",   32'(cnt_count), 32'd3);
    step(); #1;

    // reset mid-MOVE: 0 -> 4 (tie, up)
    preset(3'd0);
    cmd_valid = 1'b1; cmd_target = 3'd4; cmd_dwell = 4'd0;
    step(); cmd_valid = 1'b0; #1;
    check("rst.busy1", 32'(busy), 32'd1);
    check("rst.en1",   32'(cnt_enable), 32'd1);
    step(); reset_n = 1'b0; #1;
    check_reset_outputs("rst.async");
    step();
    check_reset_outputs("rst.held");
    step(); reset_n = 1'b1; #1;
    check("rst.no_done", 32'(done), 32'd0);
    preset(3'd3);
    // 3 -> 2: dist_up 7, down 1 step, 1 dwell cycle
    run_cmd("after_rst", 3'd2, 4'd1, 1'b0, DIR_DOWN, 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_move_ctrl.md
# updown_move_ctrl

Command-driven sequencer that steers an external 3-bit up/down counter (enable/direction inputs; count output) to a requested target value. It takes the shortest path around the modulo-2^COUNT_W ring, holds at the target for a programmed dwell time, then reports completion. It sits between a command source and the counter and is the counter's only driver of enable and direction.

## Interface
- COUNT_W, 3: counter width; must match the controlled counter.
- DWELL_W, 4: dwell-count width; maximum dwell is 2^DWELL_W-1 cycles.

- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_target  in  COUNT_W  target count, sampled on accept
- cmd_dwell  in  DWELL_W  hold cycles at target, sampled on accept
- abort  in  1  terminate the active command
- cnt_count  in  COUNT_W  current value from the counter
- cnt_enable  out  1  counter step enable
- cnt_direction  out  1  1 = up, 0 = down
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- done_aborted  out  1  qualifies done: the command was aborted

## Operation
- FSM states: IDLE, MOVE, DWELL, DONE. Encoding is registered.
- **IDLE**
  - cmd_ready=1.
  - Accept on cmd_valid & cmd_ready.
  - Latch target_q, dwell_q, dir_q.
  - Go to MOVE.
- **Direction rule**
  - dist_up = (cmd_target - cnt_count) mod 2^COUNT_W, evaluated at the accept cycle.
  - dir_q = 1 if dist_up <= 2^(COUNT_W-1), else 0. A tie goes up.
- **MOVE**
  - cnt_enable = (cnt_count != target_q) & ~abort. This is combinational.
  - cnt_direction = dir_q.
  - When cnt_count == target_q: go to DWELL if dwell_q != 0, else go to DONE.
- **DWELL**
  - cnt_enable=0.
  - The timer loads dwell_q on entry and decrements each cycle.
  - Exit to DONE in the cycle the timer reads 1, so DWELL lasts exactly dwell_q cycles.
- **DONE**
  - done=1 for one cycle, then go to IDLE.
  - done_aborted=1 only if reached via abort.
- **abort**
  - In MOVE or DWELL: cnt_enable forced 0 the same cycle; next state is DONE with done_aborted=1.
  - Ignored in IDLE and DONE.
  - abort together with an accept in IDLE: the command is accepted and abort has no effect.
- **Outputs by state**
  - busy = (state != IDLE).
  - cnt_direction holds dir_q in every state. Its value is only meaningful while cnt_enable=1.
- Arithmetic is unsigned modulo 2^COUNT_W. Wrap from 7 to 0 and from 0 to 7 is normal travel.

## Timing
- **Reset (reset_n=0)**
  - state=IDLE, cmd_ready=1, cnt_enable=0, cnt_direction=1, busy=0, done=0, done_aborted=0.
  - Latched target, dwell and timer cleared.
  - Reset asserted mid-command aborts silently: no done pulse.
- **Latency**
  - Accept at edge E0; d = steps on the chosen path; N = dwell.
  - MOVE occupies cycles 1..d+1, with cnt_enable=1 in the first d cycles.
  - DWELL occupies cycles d+2..d+1+N.
  - done is asserted in cycle d+2+N.
  - cmd_ready=1 again in cycle d+3+N.
- Throughput: one command per d+N+3 cycles. No command queueing.
- The counter is assumed to change only on cnt_enable. Other agents moving it are out of scope; MOVE re-tracks cnt_count each cycle.

## Structure
- Package updown_ctrl_pkg contains:
  - state_t enum {IDLE, MOVE, DWELL, DONE}
  - DIR_UP=1'b1, DIR_DOWN=1'b0
  - a default COUNT_W localparam
- Sub-module dwell_timer:
  - DWELL_W-bit loadable down-counter
  - inputs: load, load_val, dec
  - output: last flag (value==1)
- The FSM and direction compare stay in the top module.

## Test plan
- cnt_count=1, target=6, dwell=0:
  - dist_up=5 > 4, so direction down.
  - Counter goes 1→0→7→6; cnt_enable high 3 cycles with cnt_direction=0.
  - done at E0+5, done_aborted=0.
- cnt_count=2, target=6, dwell=3:
  - tie, so direction up; 4 enable cycles, then 3 DWELL cycles.
  - done at E0+9.
- target == cnt_count=5, dwell=0:
  - cnt_enable never asserts.
  - done at E0+2; cmd_ready at E0+3.
- Abort in the 2nd DWELL cycle:
  - done=1 and done_aborted=1 the next cycle.
  - cnt_enable stays 0; IDLE after.
- cmd_valid held continuously with two commands:
  - cmd_ready=0 while busy.
  - The second command is accepted exactly one cycle after done.
- reset_n pulled low mid-MOVE:
  - All outputs immediately at reset values, with no done pulse.
  - The next command after release is accepted normally.
